if_id_inst_buf: RTL and testbench
=================================

# if_id_inst_buf

Pipeline register and instruction hold buffer between the fetch stage and the decode stage of the five-stage MIPS core. It latches the fetch-stage `{ce, pc}` bundle and pairs it with the synchronous instruction-SRAM read data that returns one cycle later. While decode is stalled, it keeps that pair stable even though the SRAM output keeps changing. It also inserts bubbles on flush and on the stall boundary, and it counts retired fetches and held cycles for debug.

## Interface
- `STALL_W`, 6: stall vector width; bit 0 = IF, bit 1 = ID, bit 2 = EX, higher bits are downstream stages.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  STALL_W  stall vector from the stall controller; 1 = stop.
- `flush`  in  1  exception/eret flush; kills the instruction entering decode.
- `if_to_id_bus`  in  33  `{ce, pc[31:0]}` from fetch.
- `inst_sram_rdata`  in  32  instruction SRAM read data; valid the cycle after the address was presented.
- `id_valid`  out  1  decode slot holds a real instruction.
- `id_pc`  out  32  PC of the decode-slot instruction.
- `id_inst`  out  32  instruction word for decode.
- `id_bus`  out  65  `{id_valid, id_pc, id_inst}`.
- `fetch_cnt`  out  32  number of instructions accepted into decode.
- `hold_cnt`  out  32  number of cycles `id_inst` was served from the hold buffer.

## Operation
- Slot register `{v_q, pc_q}`, priority order at each edge:
  - `rst`: clear to `{0, 0}`.
  - `flush`: clear to `{0, 0}`.
  - `stall[1]=1 && stall[2]=0`: decode stalls while EX advances. Insert a bubble: clear to `{0, 0}`.
  - `stall[1]=0`: load `{ce, pc}` from `if_to_id_bus`.
  - Otherwise hold.
- Hold buffer: `held` flag plus 32-bit `buf_q`.
  - At an edge where `held=0`, `stall[1]=1`, `stall[2]=1` and `v_q=1`: set `buf_q <= inst_sram_rdata` and `held <= 1`. This captures the word belonging to the stalled `pc_q`.
  - At an edge where `stall[1]=0`, or on `flush`, or on `rst`: `held <= 0`.
  - While `held=1`: `buf_q` is never rewritten.
- Output selection (combinational):
  - `id_inst = !v_q ? 0 : (held ? buf_q : inst_sram_rdata)`.
  - `id_valid = v_q`, `id_pc = pc_q`.
- `fetch_cnt`: increments at each edge where the slot loads with `ce=1` and `flush=0`.
- `hold_cnt`: increments at each edge where `held=1`.
- Both counters wrap modulo 2^32.

## Timing
- Reset values: `id_valid=0`, `id_pc=0`, `id_inst=0`, `id_bus=0`, `fetch_cnt=0`, `hold_cnt=0`, `held=0`, `buf_q=0`.
- Latency: `{ce, pc}` presented in cycle N appears on `id_pc` in cycle N+1, together with `inst_sram_rdata` for that PC.
- The word is taken directly from the SRAM in the first stalled cycle. It is served from `buf_q` from the second stalled cycle until the first cycle after `stall[1]` drops.
- `flush` has priority over stall. A flush during a held stall drops the buffered word, and `id_valid=0` the next cycle.
- `flush` and `stall[1]=0` in the same cycle: the slot is cleared, not loaded, and `fetch_cnt` does not increment.
- `rst` asserted mid-stall: all state clears at that edge and stall inputs are ignored.
- Branch delay slot: no flush on branch. The delay-slot instruction flows normally.
- No combinational path from `stall` or `flush` to any output. Outputs depend only on registers and `inst_sram_rdata`.

## Test plan
- Reset, then stream `pc=0xbfc00000, 0xbfc00004, 0xbfc00008` with `ce=1` and SRAM words `0x24010001, 0x24020002, 0x24030003` -> each `{pc, inst}` pair appears one cycle after presentation; `fetch_cnt=3`.
- Stall `stall=6'b000111` for 4 cycles at `pc=0xbfc00004`, while SRAM output changes to `0xdeadbeef` after the first stall cycle -> `id_pc` holds `0xbfc00004`; `id_inst` stays `0x24020002` in all cycles; `hold_cnt=3`.
- `stall=6'b000011` for one cycle -> next cycle `id_valid=0`, `id_inst=0`; the following instruction enters normally after release.
- Assert `flush` during a held stall -> next cycle `id_valid=0`, `held=0`; after release the new PC `0xbfc00380` loads with its SRAM word.
- `flush=1` with `stall=0` and `ce=1` -> slot cleared; `fetch_cnt` unchanged.
- Assert `rst` mid-stall with `buf_q=0x24020002` -> all outputs and counters read 0 on the next cycle.

Source files
------------

// File: rtl/if_id_inst_buf.sv
// ---------------------------------------------------------------------------
// if_id_inst_buf
//
// Fetch/decode pipeline register with an instruction hold buffer for the
// five-stage MIPS core. The fetch stage hands over {ce, pc}. The matching
// instruction word arrives from the synchronous instruction SRAM one cycle
// later, so it lines up with the registered PC. While decode is stalled, the
// SRAM output keeps moving. The first word seen for the stalled PC is
// therefore captured and replayed until decode advances again.
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   stall[STALL_W]   stall vector (bit0 IF, bit1 ID, bit2 EX, ...), 1 = stop
//   flush            exception/eret flush, kills the decode-slot instruction
//   if_to_id_bus     {ce, pc[31:0]} from fetch
//   inst_sram_rdata  instruction SRAM read data (address of previous cycle)
//   id_valid         decode slot holds a real instruction
//   id_pc            PC of the decode-slot instruction
//   id_inst          instruction word for decode (0 when slot is empty)
//   id_bus           {id_valid, id_pc, id_inst}
//   fetch_cnt        instructions accepted into decode (wraps)
//   hold_cnt         cycles id_inst was served from the hold buffer (wraps)
// ---------------------------------------------------------------------------
module if_id_inst_buf #(
   parameter int STALL_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [32:0]        if_to_id_bus,
   input  logic [31:0]        inst_sram_rdata,
   output logic               id_valid,
   output logic [31:0]        id_pc,
   output logic [31:0]        id_inst,
   output logic [64:0]        id_bus,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        hold_cnt
);

   logic        fetch_ce;
   logic [31:0] fetch_pc;
   logic        id_stall;
   logic        ex_stall;
   logic        bubble;
   logic        load;
   logic        capture;

   logic        v_q;
   logic [31:0] pc_q;
   logic        held;
   logic [31:0] buf_q;

   // Only the ID and EX stall bits matter here; the rest of the vector is
   // consumed by other stages.
   logic        unused_stall_bits;
   assign unused_stall_bits = ^{stall[STALL_W-1:3], stall[0]};

   assign fetch_ce = if_to_id_bus[32];
   assign fetch_pc = if_to_id_bus[31:0];
   assign id_stall = stall[1];
   assign ex_stall = stall[2];

   // Decode stalls while EX moves on: the slot must become a bubble so the
   // instruction is not issued twice downstream.
   assign bubble  = id_stall && !ex_stall;
   assign load    = !id_stall && !flush;
   // Whole front end frozen with a live instruction: grab the SRAM word now,
   // while it still belongs to pc_q.
   assign capture = !held && id_stall && ex_stall && v_q;

   // ---- IF -> ID boundary: slot, hold buffer and debug counters ----------
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q       <= 1'b0;
         pc_q      <= 32'd0;
         held      <= 1'b0;
         buf_q     <= 32'd0;
         fetch_cnt <= 32'd0;
         hold_cnt  <= 32'd0;
      end else begin
         if (flush || bubble) begin
            v_q  <= 1'b0;
            pc_q <= 32'd0;
         end else if (!id_stall) begin
            v_q  <= fetch_ce;
            pc_q <= fetch_pc;
         end

         if (flush || !id_stall) begin
            held <= 1'b0;
         end else if (capture) begin
            held  <= 1'b1;
            buf_q <= inst_sram_rdata;
         end

         if (load && fetch_ce) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (held) begin
            hold_cnt <= hold_cnt + 32'd1;
         end
      end
   end

   // Outputs see only registered state and the SRAM data, never stall/flush.
   assign id_valid = v_q;
   assign id_pc    = pc_q;
   assign id_inst  = !v_q ? 32'd0 : (held ? buf_q : inst_sram_rdata);
   assign id_bus   = {id_valid, id_pc, id_inst};

endmodule

// File: tb/tb_if_id_inst_buf.sv
module tb_if_id_inst_buf;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [32:0] if_to_id_bus;
   logic [31:0] inst_sram_rdata;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [64:0] id_bus;
   logic [31:0] fetch_cnt;
   logic [31:0] hold_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   if_id_inst_buf #(.STALL_W(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .if_to_id_bus    (if_to_id_bus),
      .inst_sram_rdata (inst_sram_rdata),
      .id_valid        (id_valid),
      .id_pc           (id_pc),
      .id_inst         (id_inst),
      .id_bus          (id_bus),
      .fetch_cnt       (fetch_cnt),
      .hold_cnt        (hold_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic [5:0]  stall;
      logic        flush;
      logic        ce;
      logic [31:0] pc;
      logic [31:0] rdata;
      logic        chk;
      logic        ev;
      logic [31:0] epc;
      logic [31:0] einst;
      logic [31:0] efc;
      logic [31:0] ehc;
   } vec_t;

   vec_t vecs[14];

   task automatic cmp(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs just after the edge, sample mid-cycle.
   task automatic step(input logic r, input logic [5:0] s, input logic f,
                       input logic c, input logic [31:0] p, input logic [31:0] d,
                       input logic chk, input string tag, input logic ev,
                       input logic [31:0] epc, input logic [31:0] einst,
                       input logic [31:0] efc, input logic [31:0] ehc);
      rst             = r;
      stall           = s;
      flush           = f;
      if_to_id_bus    = {c, p};
      inst_sram_rdata = d;
      #4;
      if (chk) begin
         cmp({tag, ".id_valid"},  {64'd0, id_valid}, {64'd0, ev});
         cmp({tag, ".id_pc"},     {33'd0, id_pc},    {33'd0, epc});
         cmp({tag, ".id_inst"},   {33'd0, id_inst},  {33'd0, einst});
         cmp({tag, ".id_bus"},    id_bus,            {ev, epc, einst});
         cmp({tag, ".fetch_cnt"}, {33'd0, fetch_cnt}, {33'd0, efc});
         cmp({tag, ".hold_cnt"},  {33'd0, hold_cnt},  {33'd0, ehc});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           rst  stall   fl  ce  pc            rdata         chk ev  epc           einst         fc  hc
      vecs[0]  = '{1'b1, 6'd0,  1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        32'd0, 32'd0};
      // reset state; SRAM garbage is masked while slot is empty
      vecs[1]  = '{1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc00000, 32'h11111111, 1'b1, 1'b0, 32'h0,        32'h0,        32'd0, 32'd0};
      vecs[2]  = '{1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc00004, 32'h24010001, 1'b1, 1'b1, 32'hbfc00000, 32'h24010001, 32'd1, 32'd0};
      // full stall begins while bfc00004 sits in decode
      vecs[3]  = '{1'b0, 6'h07, 1'b0, 1'b1, 32'hbfc00008, 32'h24020002, 1'b1, 1'b1, 32'hbfc00004, 32'h24020002, 32'd2, 32'd0};
      vecs[4]  = '{1'b0, 6'h07, 1'b0, 1'b1, 32'hbfc00008, 32'hdeadbeef, 1'b1, 1'b1, 32'hbfc00004, 32'h24020002, 32'd2, 32'd0};
      vecs[5]  = '{1'b0, 6'h07, 1'b0, 1'b1, 32'hbfc00008, 32'hdeadbeef, 1'b1, 1'b1, 32'hbfc00004, 32'h24020002, 32'd2, 32'd1};
      vecs[6]  = '{1'b0, 6'h07, 1'b0, 1'b1, 32'hbfc00008, 32'hdeadbeef, 1'b1, 1'b1, 32'hbfc00004, 32'h24020002, 32'd2, 32'd2};
      // release: still served from the buffer this cycle
      vecs[7]  = '{1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc00008, 32'hdeadbeef, 1'b1, 1'b1, 32'hbfc00004, 32'h24020002, 32'd2, 32'd3};
      // bubble stall (ID stops, EX moves)
      vecs[8]  = '{1'b0, 6'h03, 1'b0, 1'b1, 32'hbfc0000c, 32'h24030003, 1'b1, 1'b1, 32'hbfc00008, 32'h24030003, 32'd3, 32'd4};
      vecs[9]  = '{1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc0000c, 32'h55555555, 1'b1, 1'b0, 32'h0,        32'h0,        32'd3, 32'd4};
      // ce=0 fetch does not count and yields an empty slot
      vecs[10] = '{1'b0, 6'd0,  1'b0, 1'b0, 32'hbfc00010, 32'h24040004, 1'b1, 1'b1, 32'hbfc0000c, 32'h24040004, 32'd4, 32'd4};
      vecs[11] = '{1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc00014, 32'h66666666, 1'b1, 1'b0, 32'hbfc00010, 32'h0,        32'd4, 32'd4};
      vecs[12] = '{1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc00018, 32'h24050005, 1'b1, 1'b1, 32'hbfc00014, 32'h24050005, 32'd5, 32'd4};
      vecs[13] = '{1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc0001c, 32'h24060006, 1'b1, 1'b1, 32'hbfc00018, 32'h24060006, 32'd6, 32'd4};

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].ce, vecs[i].pc,
              vecs[i].rdata, vecs[i].chk, $sformatf("vec%0d", i), vecs[i].ev,
              vecs[i].epc, vecs[i].einst, vecs[i].efc, vecs[i].ehc);
      end

      // Flush during a held stall, then the handler PC loads normally.
      step(1'b0, 6'h07, 1'b0, 1'b1, 32'hbfc00020, 32'h24070007, 1'b1, "fl_s1",  1'b1, 32'hbfc0001c, 32'h24070007, 32'd7, 32'd4);
      step(1'b0, 6'h07, 1'b0, 1'b1, 32'hbfc00020, 32'hdeadbeef, 1'b1, "fl_s2",  1'b1, 32'hbfc0001c, 32'h24070007, 32'd7, 32'd4);
      step(1'b0, 6'h07, 1'b1, 1'b1, 32'hbfc00380, 32'hdeadbeef, 1'b1, "fl_s3",  1'b1, 32'hbfc0001c, 32'h24070007, 32'd7, 32'd5);
      step(1'b0, 6'h07, 1'b0, 1'b1, 32'hbfc00380, 32'hdeadbeef, 1'b1, "fl_s4",  1'b0, 32'h0,        32'h0,        32'd7, 32'd6);
      step(1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc00380, 32'hdeadbeef, 1'b1, "fl_rel", 1'b0, 32'h0,        32'h0,        32'd7, 32'd6);
      // Handler word arrives; flush with stall=0 in the same cycle.
      step(1'b0, 6'd0,  1'b1, 1'b1, 32'hbfc00384, 32'h40806000, 1'b1, "fl_new", 1'b1, 32'hbfc00380, 32'h40806000, 32'd8, 32'd6);
      step(1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc00388, 32'h77777777, 1'b1, "fl_ld",  1'b0, 32'h0,        32'h0,        32'd8, 32'd6);

      // Reset in the middle of a held stall.
      step(1'b0, 6'h07, 1'b0, 1'b1, 32'hbfc0038c, 32'h24020002, 1'b1, "rs_s1",  1'b1, 32'hbfc00388, 32'h24020002, 32'd9, 32'd6);
      step(1'b1, 6'h07, 1'b0, 1'b1, 32'hbfc0038c, 32'hdeadbeef, 1'b1, "rs_s2",  1'b1, 32'hbfc00388, 32'h24020002, 32'd9, 32'd6);
      step(1'b0, 6'h07, 1'b0, 1'b1, 32'hbfc0038c, 32'hdeadbeef, 1'b1, "rs_clr", 1'b0, 32'h0,        32'h0,        32'd0, 32'd0);
      step(1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc0038c, 32'h12345678, 1'b1, "rs_rel", 1'b0, 32'h0,        32'h0,        32'd0, 32'd0);
      step(1'b0, 6'd0,  1'b0, 1'b1, 32'hbfc00390, 32'h240a000a, 1'b1, "rs_run", 1'b1, 32'hbfc0038c, 32'h240a000a, 32'd1, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
